cons_bus_scheduler: RTL
=======================

// Module: cons_bus_scheduler
// PURPOSE
//  Shares the single bidirectional host "cons" bus between two users: the load path (kernel/input words
//  entering the device during LK_*/LI_*/CC_* states) and the result write-back path (output words leaving
//  the device). Results are buffered in a small FIFO so the compute pipeline never stalls on the bus.
//  The block schedules bus direction, inserts turnaround cycles and bounds load bursts so results drain.
// PARAMETERS
//  DATA_WIDTH           16  width of a result word on the write-back path
//  OUT_FIFO_DEPTH       4   result FIFO entries (power of two, >=2)
//  LOG2_OUT_FIFO_DEPTH  2   log2(OUT_FIFO_DEPTH); pointer width
//  MAX_LOAD_BURST       8   max consecutive load beats while the FIFO is non-empty
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  srst_in      in   1    reset; synchronous, active-high
//  load_req     in   1    controller is in a load-consuming state
//  load_ready   in   1    controller can accept a load word this cycle
//  load_valid   out  1    host word valid toward controller (host_valid gated by grant)
//  host_valid   in   1    host presents a load word on the bus
//  host_ready   out  1    device accepts host word this cycle
//  res_valid    in   1    datapath pushes a result word
//  res_data     in   DATA_WIDTH  result word
//  res_ready    out  1    FIFO not full (registered-count based)
//  drive_out    out  1    device drives the bus (direction select)
//  wb_valid     out  1    write-back word valid on bus
//  wb_data      out  DATA_WIDTH  FIFO head word
//  wb_ready     in   1    host accepts write-back word
//  fifo_count   out  LOG2_OUT_FIFO_DEPTH+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (srst_in=1 at a clk edge): state IDLE, FIFO emptied (contents discarded), burst counter 0;
//   all outputs 0 except res_ready=1. Reset mid-transfer aborts it; no partial beat is reported.
//  Load beat: host_valid && host_ready. Push: res_valid && res_ready. Pop: wb_valid && wb_ready.
//  host_ready = load_ready && grant_load; load_valid = host_valid && grant_load; grant_load only in LOAD.
//  States:
//   IDLE     : drive_out=0. FIFO full or (non-empty && !load_req) -> TURN_OUT; else load_req -> LOAD.
//   LOAD     : grant_load=1, drive_out=0. Burst counter +1 per load beat while FIFO non-empty,
//              cleared when FIFO empty. Exit -> TURN_OUT if FIFO full, or non-empty and
//              counter==MAX_LOAD_BURST; else -> IDLE if !load_req; else stay. Exit decided after this cycle's beat.
//   TURN_OUT : one cycle, drive_out=1, wb_valid=0, no grant -> DRAIN.
//   DRAIN    : drive_out=1, wb_valid=(count!=0), wb_data=FIFO head. Stays until a pop leaves
//              the FIFO empty (or count==0 on entry) -> TURN_IN. Clears burst counter.
//   TURN_IN  : one cycle, drive_out=0, no grant -> IDLE.
//  FIFO: res_ready = (count != OUT_FIFO_DEPTH); push accepted in every state.
//   Push+pop same cycle: count unchanged, both take effect. Full + pop: push refused that cycle
//   (res_ready from registered count). Empty: wb_valid=0, no bypass; push->wb_valid latency >=1 cycle.
//   Pointers wrap modulo OUT_FIFO_DEPTH; count is LOG2_OUT_FIFO_DEPTH+1 bits, never exceeds depth.
//  Words are written back in push order; no word is lost or duplicated.
//  wb_data/wb_valid hold stable while wb_valid && !wb_ready.
//  Never host_ready and wb_valid in the same cycle; drive_out changes only via TURN_* states.
// TESTING
//  T1 reset: srst_in high 2 cycles mid-DRAIN with count=3 -> next cycle IDLE, count=0, wb_valid=0, res_ready=1.
//  T2 pure load: load_req=1, host_valid=load_ready=1, 20 cycles, FIFO empty -> 20 load beats, drive_out=0 throughout.
//  T3 burst cap: load streaming, push 1 result -> exactly 8 further load beats, TURN_OUT, DRAIN pops the word,
//     TURN_IN, IDLE, LOAD resumes.
//  T4 full FIFO: push 5 words in DRAIN with wb_ready=0 -> 4 accepted, res_ready=0 on 5th;
//     raise wb_ready -> words 0..3 out in order.
//  T5 simultaneous: DRAIN count=2, push+pop each cycle for 6 cycles -> count stays 2, order preserved.
//  T6 idle drain: load_req=0, push 1 word -> TURN_OUT next cycle, wb_valid next cycle, pop -> TURN_IN, IDLE.

Source files
------------

// File: rtl/cons_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cons_bus_scheduler
// Description : Shares the bidirectional host cons bus between the load path
//               and a FIFO-buffered result write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
module cons_bus_scheduler #(
    parameter int DATA_WIDTH          = 16,
    parameter int OUT_FIFO_DEPTH      = 4,
    parameter int LOG2_OUT_FIFO_DEPTH = 2,
    parameter int MAX_LOAD_BURST      = 8
) (
    input  logic                           clk,
    input  logic                           srst_in,
    input  logic                           load_req,
    input  logic                           load_ready,
    output logic                           load_valid,
    input  logic                           host_valid,
    output logic                           host_ready,
    input  logic                           res_valid,
    input  logic [DATA_WIDTH-1:0]          res_data,
    output logic                           res_ready,
    output logic                           drive_out,
    output logic                           wb_valid,
    output logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           wb_ready,
    output logic [LOG2_OUT_FIFO_DEPTH:0]   fifo_count
);

    localparam int c_BURST_W = $clog2(MAX_LOAD_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(MAX_LOAD_BURST);
    localparam logic [LOG2_OUT_FIFO_DEPTH:0] c_FULL_COUNT = (LOG2_OUT_FIFO_DEPTH + 1)'(OUT_FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_TURN_OUT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_TURN_IN  = 3'd4
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [DATA_WIDTH-1:0]          r_mem [OUT_FIFO_DEPTH];
    logic [LOG2_OUT_FIFO_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_OUT_FIFO_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_OUT_FIFO_DEPTH:0]   r_count;
    logic [LOG2_OUT_FIFO_DEPTH:0]   w_count_next;
    logic [c_BURST_W-1:0]           r_burst;
    logic [c_BURST_W-1:0]           w_burst_next;
    logic                           w_grant_load;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_load_beat;
    logic                           w_full;
    logic                           w_nonempty;

    assign w_full       = (r_count == c_FULL_COUNT);
    assign w_nonempty   = (r_count != '0);
    assign w_grant_load = (r_state == ST_LOAD);

    assign host_ready = load_ready && w_grant_load;
    assign load_valid = host_valid && w_grant_load;
    assign drive_out  = (r_state == ST_TURN_OUT) || (r_state == ST_DRAIN);
    assign wb_valid   = (r_state == ST_DRAIN) && w_nonempty;
    // Data is forced to zero when not valid so idle/reset bus values are clean.
    assign wb_data    = wb_valid ? r_mem[r_rd_ptr] : '0;
    assign res_ready  = !w_full;
    assign fifo_count = r_count;

    assign w_push      = res_valid && res_ready;
    assign w_pop       = wb_valid && wb_ready;
    assign w_load_beat = host_valid && host_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_burst_next = r_burst;
        case (r_state)
            ST_LOAD: begin
                if (!w_nonempty) begin
                    w_burst_next = '0;
                end else if (w_load_beat && (r_burst != c_BURST_MAX)) begin
                    w_burst_next = r_burst + 1'b1;
                end
            end
            ST_DRAIN: w_burst_next = '0;
            default:  w_burst_next = r_burst;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_full || (w_nonempty && !load_req)) begin
                    w_state_next = ST_TURN_OUT;
                end else if (load_req) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Exit uses the post-beat counter so the capping beat is still granted.
                if (w_full || (w_nonempty && (w_burst_next == c_BURST_MAX))) begin
                    w_state_next = ST_TURN_OUT;
                end else if (!load_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TURN_OUT: w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (w_count_next == '0) begin
                    w_state_next = ST_TURN_IN;
                end
            end
            ST_TURN_IN: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst_in) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_burst  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_burst <= w_burst_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= res_data;
        end
    end

endmodule
`default_nettype wire
